// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Holds the fetch FSM state enum, bus widths and the default PC reset/increment values.
package fetch_pkg;

  localparam int INSN_W = 32;
  localparam int PC_W   = 32;

  localparam logic [PC_W-1:0] DEFAULT_RESET_PC = 32'h0040_0000;
  localparam logic [PC_W-1:0] DEFAULT_PC_INC   = 32'd4;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

  // Redirect targets are forced onto a word boundary.
  function automatic logic [PC_W-1:0] align_word(input logic [PC_W-1:0] addr);
    return {addr[PC_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory req/ack port plus the valid/ready port toward decode.
// master = fetch unit side; slave = memory/decode side.
interface instr_fetch_unit_if;
  import fetch_pkg::*;

  logic              imem_req;
  logic [PC_W-1:0]   imem_addr;
  logic              imem_ack;
  logic [INSN_W-1:0] imem_rdata;

  logic              ins_valid;
  logic              ins_ready;
  logic [INSN_W-1:0] ins;
  logic [PC_W-1:0]   ins_pc;
  logic [PC_W-1:0]   pc_p4;

  modport master (
    output imem_req, imem_addr, ins_valid, ins, ins_pc, pc_p4,
    input  imem_ack, imem_rdata, ins_ready
  );

  modport slave (
    input  imem_req, imem_addr, ins_valid, ins, ins_pc, pc_p4,
    output imem_ack, imem_rdata, ins_ready
  );

endinterface

// File: rtl/pc_reg.sv
// Address-wide register with load enable and asynchronous reset to a parameter value.
// Used for both the architectural PC and the saved redirect target.
module pc_reg
  import fetch_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_VAL = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_load,
  input  logic [PC_W-1:0] i_d,
  output logic [PC_W-1:0] o_q
);

  logic [PC_W-1:0] r_q;

  // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_q <= RESET_VAL;
    else if (i_load) r_q <= i_d;
  end

  assign o_q = r_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues one req/ack memory fetch at a time and hands
// the instruction to decode; redirects discard any in-flight or held instruction.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = DEFAULT_RESET_PC,
  parameter logic [PC_W-1:0] PC_INC   = DEFAULT_PC_INC
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_redirect,
  input  logic [PC_W-1:0]    i_redirect_pc,
  output logic               o_misalign,
  instr_fetch_unit_if.master bus
);

  localparam logic [1:0] ST_FETCH = FETCH;
  localparam logic [1:0] ST_HOLD  = HOLD;
  localparam logic [1:0] ST_DRAIN = DRAIN;

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic [PC_W-1:0]   w_pc;
  logic [PC_W-1:0]   w_saved;
  logic [PC_W-1:0]   w_pc_nxt;
  logic [PC_W-1:0]   w_pc_inc;
  logic [PC_W-1:0]   w_redir_tgt;
  logic              w_pc_load;
  logic              w_saved_load;
  logic              w_capture;

  logic              r_ins_valid;
  logic [INSN_W-1:0] r_ins;
  logic [PC_W-1:0]   r_ins_pc;
  logic [PC_W-1:0]   r_pc_p4;
  logic              r_misalign;

  assign w_pc_inc    = w_pc + PC_INC;
  assign w_redir_tgt = align_word(i_redirect_pc);
  assign w_capture   = (r_state == ST_FETCH) && bus.imem_ack && !i_redirect;

  pc_reg #(.RESET_VAL(RESET_PC)) u_pc (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_pc_load),
    .i_d    (w_pc_nxt),
    .o_q    (w_pc)
  );

  pc_reg #(.RESET_VAL('0)) u_saved (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_saved_load),
    .i_d    (w_redir_tgt),
    .o_q    (w_saved)
  );

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_state_nxt  = r_state;
    w_pc_load    = 1'b0;
    w_pc_nxt     = w_redir_tgt;
    w_saved_load = 1'b0;
    case (r_state)
      ST_FETCH: begin
        if (bus.imem_ack) begin
          if (i_redirect) w_pc_load = 1'b1;
          else            w_state_nxt = ST_HOLD;
        end else if (i_redirect) begin
          w_saved_load = 1'b1;
          w_state_nxt  = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // The old request must complete; its data is dropped and the latest target wins.
        w_saved_load = i_redirect;
        if (bus.imem_ack) begin
          w_pc_load   = 1'b1;
          w_pc_nxt    = i_redirect ? w_redir_tgt : w_saved;
          w_state_nxt = ST_FETCH;
        end
      end
      ST_HOLD: begin
        if (i_redirect) begin
          w_pc_load   = 1'b1;
          w_state_nxt = ST_FETCH;
        end else if (bus.ins_ready) begin
          w_pc_load   = 1'b1;
          w_pc_nxt    = w_pc_inc;
          w_state_nxt = ST_FETCH;
        end
      end
      default: w_state_nxt = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_FETCH;
      r_ins_valid <= 1'b0;
      r_ins       <= '0;
      r_ins_pc    <= RESET_PC;
      r_pc_p4     <= RESET_PC + PC_INC;
      r_misalign  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ins_valid <= (w_state_nxt == ST_HOLD);
      if (w_capture) begin
        r_ins    <= bus.imem_rdata;
        r_ins_pc <= w_pc;
        r_pc_p4  <= w_pc_inc;
      end
      if (i_redirect && (i_redirect_pc[1:0] != 2'b00)) r_misalign <= 1'b1;
    end
  end

  // The PC does not move while a request is outstanding, so it doubles as the latched address.
  assign bus.imem_req  = !rst && (r_state != ST_HOLD);
  assign bus.imem_addr = w_pc;
  assign bus.ins_valid = r_ins_valid;
  assign bus.ins       = r_ins;
  assign bus.ins_pc    = r_ins_pc;
  assign bus.pc_p4     = r_pc_p4;
  assign o_misalign    = r_misalign;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios followed by random
// redirect/ack/ready traffic, all checked against a transaction-level model.
module tb_instr_fetch_unit;
  import fetch_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0040_0000;
  localparam logic [31:0] XORK   = 32'hA5A5_A5A5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        misalign;

  instr_fetch_unit_if bus ();

  instr_fetch_unit dut (
    .clk           (clk),
    .rst           (rst),
    .i_redirect    (redirect),
    .i_redirect_pc (redirect_pc),
    .o_misalign    (misalign),
    .bus           (bus)
  );

  always #5 clk = ~clk;

  // Memory returns a word derived from the address; junk when not acking.
  assign bus.imem_rdata = bus.imem_ack ? (bus.imem_addr ^ XORK) : 32'h0BAD_0BAD;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: next address that must be delivered, sticky misalign,
  // and whether the outstanding request has been overtaken by a redirect.
  logic [31:0] exp_next;
  logic        exp_mis;
  logic        dirty;
  logic        exp_deliver;
  logic        have_prev;
  logic        prev_req, prev_ack, prev_valid, prev_ready, prev_redirect;
  logic [31:0] prev_addr;
  logic [31:0] deliv_q[$];
  logic [31:0] fresh_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic observe();
    logic fresh;
    check("misalign", {31'd0, misalign}, {31'd0, exp_mis});
    check("req_vs_valid", {31'd0, bus.imem_req}, {31'd0, !bus.ins_valid});
    if (have_prev) begin
      if (prev_req && !prev_ack) check("addr_stable", bus.imem_addr, prev_addr);
      fresh = bus.imem_req && (!prev_req || prev_ack);
      if (fresh) begin
        check("fresh_addr", bus.imem_addr, exp_next);
        fresh_q.push_back(bus.imem_addr);
      end
      if (prev_req && prev_ack) begin
        check("deliver", {31'd0, bus.ins_valid}, {31'd0, exp_deliver});
        if (exp_deliver && bus.ins_valid) begin
          check("ins_pc", bus.ins_pc, exp_next);
          check("ins", bus.ins, exp_next ^ XORK);
          check("pc_p4", bus.pc_p4, exp_next + 32'd4);
          deliv_q.push_back(bus.ins_pc);
        end
      end
      if (prev_valid) begin
        if (prev_ready || prev_redirect) begin
          check("valid_drop", {31'd0, bus.ins_valid}, 32'd0);
        end else begin
          check("valid_hold", {31'd0, bus.ins_valid}, 32'd1);
          check("ins_pc_hold", bus.ins_pc, exp_next);
          check("ins_hold", bus.ins, exp_next ^ XORK);
        end
      end
    end
  endtask

  task automatic step(input logic rd, input logic [31:0] rpc, input logic ak, input logic rdy);
    @(negedge clk);
    observe();
    redirect      = rd;
    redirect_pc   = rpc;
    bus.imem_ack  = ak & bus.imem_req;
    bus.ins_ready = rdy;
    if (bus.imem_req) begin
      if (rd) dirty = 1'b1;
      if (bus.imem_ack) begin
        exp_deliver = !dirty;
        dirty       = 1'b0;
      end
    end
    if (rd) begin
      exp_next = {rpc[31:2], 2'b00};
      if (rpc[1:0] != 2'b00) exp_mis = 1'b1;
    end else if (bus.ins_valid && rdy) begin
      exp_next = bus.ins_pc + 32'd4;
    end
    prev_req      = bus.imem_req;
    prev_ack      = bus.imem_ack;
    prev_valid    = bus.ins_valid;
    prev_ready    = rdy;
    prev_redirect = rd;
    prev_addr     = bus.imem_addr;
    have_prev     = 1'b1;
  endtask

  task automatic reset_dut(input logic ack_pending);
    @(negedge clk);
    rst           = 1'b1;
    redirect      = 1'b0;
    redirect_pc   = '0;
    bus.imem_ack  = ack_pending;
    bus.ins_ready = 1'b0;
    #1;
    check("rst_req", {31'd0, bus.imem_req}, 32'd0);
    check("rst_valid", {31'd0, bus.ins_valid}, 32'd0);
    check("rst_ins", bus.ins, 32'd0);
    check("rst_ins_pc", bus.ins_pc, RST_PC);
    check("rst_pc_p4", bus.pc_p4, RST_PC + 32'd4);
    check("rst_misalign", {31'd0, misalign}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    bus.imem_ack = 1'b0;
    rst          = 1'b0;
    #1;
    check("rst_first_addr", bus.imem_addr, RST_PC);
    check("rst_first_req", {31'd0, bus.imem_req}, 32'd1);
    exp_next      = RST_PC;
    exp_mis       = 1'b0;
    dirty         = 1'b0;
    exp_deliver   = 1'b0;
    have_prev     = 1'b1;
    prev_req      = 1'b1;
    prev_ack      = 1'b0;
    prev_valid    = 1'b0;
    prev_ready    = 1'b0;
    prev_redirect = 1'b0;
    prev_addr     = RST_PC;
    fresh_q.push_back(RST_PC);
  endtask

  initial begin
    int n_before;
    logic [31:0] rpc;
    bus.imem_ack  = 1'b0;
    bus.ins_ready = 1'b0;
    have_prev     = 1'b0;

    // 1: zero-wait memory, decode always ready
    reset_dut(1'b0);
    step(0, 0, 1, 1);
    step(0, 0, 1, 1);
    check("t1_ins_pc", bus.ins_pc, 32'h0040_0000);
    check("t1_pc_p4", bus.pc_p4, 32'h0040_0004);
    repeat (5) step(0, 0, 1, 1);
    check("t1_req1", fresh_q[1], 32'h0040_0004);
    check("t1_req2", fresh_q[2], 32'h0040_0008);
    check("t1_rate", deliv_q.size(), 3);
    check("t1_first", deliv_q[0], 32'h0040_0000);

    // 2: slow ack and a stalled decode
    repeat (4) step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    repeat (3) step(0, 0, 0, 0);
    step(0, 0, 1, 0);
    repeat (4) step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    check("t2_count", deliv_q.size(), 5);
    check("t2_prev", deliv_q[3], 32'h0040_000C);
    check("t2_last", deliv_q[4], 32'h0040_0010);

    // 3: redirect while waiting, second redirect while draining
    step(1, 32'h0000_1000, 0, 0);
    step(1, 32'h0000_2000, 0, 0);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    check("t3_addr", fresh_q[$], 32'h0000_2000);
    check("t3_no_deliv", deliv_q.size(), 5);

    // 4: redirect races consume; misaligned redirect
    step(0, 0, 1, 0);
    step(1, 32'h0000_0080, 0, 1);
    step(0, 0, 0, 0);
    check("t4_addr", fresh_q[$], 32'h0000_0080);
    step(0, 0, 1, 0);
    step(1, 32'h0000_0082, 0, 0);
    step(0, 0, 0, 0);
    check("t4_mis_addr", fresh_q[$], 32'h0000_0080);
    check("t4_mis", {31'd0, misalign}, 32'd1);

    // 5: wrap at the top of the address space
    step(1, 32'hFFFF_FFFC, 1, 0);
    step(0, 0, 1, 0);
    step(0, 0, 0, 1);
    check("t5_pc_p4", bus.pc_p4, 32'h0000_0000);
    step(0, 0, 0, 0);
    check("t5_addr", fresh_q[$], 32'h0000_0000);

    // 6: reset in the middle of a drain with an ack arriving
    step(1, 32'h0000_3000, 0, 0);
    step(0, 0, 0, 0);
    reset_dut(1'b1);
    n_before = deliv_q.size();
    repeat (3) step(0, 0, 0, 0);
    check("t6_no_stale", {31'd0, bus.ins_valid}, 32'd0);
    check("t6_no_deliv", deliv_q.size(), n_before);
    step(0, 0, 1, 1);
    step(0, 0, 0, 1);
    check("t6_first", deliv_q[$], RST_PC);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      rpc = $urandom();
      if ($urandom_range(0, 7) != 0) rpc[1:0] = 2'b00;
      step(($urandom_range(0, 7) == 0), rpc, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
    end
    step(0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Consumer end of the next-PC path: holds the architectural PC register and fetches one instruction at that address over a req/ack instruction-memory port.
- Presents the instruction, its PC and PC+4 to decode with a valid/ready handshake.
- Accepts redirects (branch/jump/interrupt target) from the next-PC logic.
- Sits between the next-PC selector and the decode stage.

Parameters:
RESET_PC, 32'h0040_0000, PC value loaded on reset (word-aligned).
PC_INC, 4, PC increment per sequential instruction.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
redirect  input  1  load redirect_pc as the next fetch address
redirect_pc  input  32  redirect target (branch/jump/entry point)
imem_req  output  1  instruction-memory request
imem_addr  output  32  request address, word-aligned
imem_ack  input  1  memory accepts request; imem_rdata valid this cycle
imem_rdata  input  32  instruction word
ins_valid  output  1  ins/ins_pc/pc_p4 valid to decode
ins_ready  input  1  decode consumes the instruction this cycle
ins  output  32  fetched instruction
ins_pc  output  32  address of ins
pc_p4  output  32  ins_pc + PC_INC, 32-bit wrap
misalign  output  1  sticky: a redirect_pc with nonzero [1:0] was taken

Behaviour:
Reset (async, immediate):
- pc = RESET_PC; state = FETCH; saved target = 0.
- imem_req = 0; ins_valid = 0; ins = 0; ins_pc = RESET_PC; pc_p4 = RESET_PC+4; misalign = 0.
- Memory shares rst and abandons any outstanding request.

States: FETCH, HOLD, DRAIN.
- imem_req = 1 in FETCH and DRAIN, 0 in HOLD and during rst.
- imem_addr = pc in FETCH; latched request address in DRAIN.
- Once raised, req and addr stay stable until the ack cycle.

FETCH:
- ack and no redirect: ins <= rdata; ins_pc <= pc; pc_p4 <= pc+PC_INC; ins_valid <= 1; go to HOLD.
- ack and redirect: discard rdata; pc <= redirect_pc; stay in FETCH. The new request issues next cycle.
- no ack and redirect: saved target <= redirect_pc; go to DRAIN.
- no ack and no redirect: hold.

DRAIN:
- Keep the old request until ack.
- Further redirects overwrite the saved target (latest wins).
- On ack: discard rdata; pc <= saved target, or redirect_pc if redirect is high in the same cycle; go to FETCH.

HOLD (ins_valid = 1, outputs stable):
- redirect (with or without ins_ready): pc <= redirect_pc; ins_valid <= 0; go to FETCH. Redirect wins; an unconsumed instruction is dropped.
- ins_ready and no redirect: pc <= pc+PC_INC; ins_valid <= 0; go to FETCH.
- neither: hold indefinitely.

Redirect alignment:
- Every taken redirect loads {redirect_pc[31:2], 2'b00}.
- If redirect_pc[1:0] != 0, misalign <= 1. It stays set until rst.

Arithmetic and timing:
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 = 0.
- Latency from ack to ins_valid is 1 cycle.
- Best case is one instruction per 2 cycles (FETCH ack, HOLD consume).
- ins_valid never asserts for discarded data.

Decomposition:
- Package fetch_pkg: state enum {FETCH, HOLD, DRAIN}; INSN_W = 32; PC_W = 32; default RESET_PC; PC_INC.
- One sub-module, pc_reg: 32-bit register with load enable and async reset-to-parameter. Used for pc and saved target.
- FSM, incrementer and output registers live in instr_fetch_unit.

Test Plan:
1. Reset then zero-wait memory, ins_ready = 1, memory returns addr^32'hA5A5_A5A5:
   - req addresses 0x0040_0000, 0x0040_0004, 0x0040_0008.
   - ins_pc/pc_p4 pairs (0x0040_0000/0x0040_0004) …
   - one ins_valid every 2 cycles.
2. Ack delayed 3 cycles, ins_ready low 4 cycles in HOLD:
   - imem_addr stable until ack.
   - ins/ins_pc held constant while ins_valid = 1.
   - exactly one instruction per address.
3. Redirect to 0x0000_1000 in FETCH two cycles before ack, second redirect to 0x0000_2000 in DRAIN:
   - old data discarded; no ins_valid.
   - next req address 0x0000_2000.
4. Redirect to 0x0000_0080 in the same cycle as ins_ready in HOLD:
   - next req 0x0000_0080, not ins_pc+4.
   - redirect to 0x0000_0082 → address 0x0000_0080 and misalign = 1, held until rst.
5. Redirect to 0xFFFF_FFFC, consume:
   - pc_p4 = 0x0000_0000.
   - next req address 0x0000_0000.
6. Assert rst mid-DRAIN with ack pending:
   - outputs reset immediately, misalign cleared.
   - after release, first req address RESET_PC; stale data never surfaces.
